// File: rtl/cla_seq_adder.sv
// Multi-cycle adder that time-shares one 4-bit carry-lookahead slice across an
// nBITS-wide operand pair, LSB slice first, with valid/ready on both sides.

module cla4_slice (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_c
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    always_comb begin
        w_g    = i_a & i_b;
        w_p    = i_a ^ i_b;
        w_c[0] = i_c;
        w_c[1] = w_g[0] | (w_p[0] & i_c);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & i_c);
        o_c    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);
        o_s    = w_p ^ w_c;
    end
endmodule

module cla_seq_adder #(
    parameter int nBITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [nBITS-1:0] ain,
    input  logic [nBITS-1:0] bin,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [nBITS-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int nSLICES = nBITS / 4;
    localparam int IDXW    = (nSLICES > 1) ? $clog2(nSLICES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IDXW-1:0]   r_idx;
    logic [nBITS-1:0]  r_a;
    logic [nBITS-1:0]  r_b;
    logic [nBITS-1:0]  r_sum;
    logic              r_carry;
    logic              r_cout;
    logic [3:0]        w_a_sl;
    logic [3:0]        w_b_sl;
    logic [3:0]        w_s;
    logic              w_co;
    logic              w_last;

    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int k = 0; k < nSLICES; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_a_sl = r_a[4*k +: 4];
                w_b_sl = r_b[4*k +: 4];
            end
        end
    end

    assign w_last = (r_idx == IDXW'(nSLICES - 1));

    cla4_slice u_slice (
        .i_a (w_a_sl),
        .i_b (w_b_sl),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Unused encoding falls through to default and returns to IDLE.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= ain;
                        r_b     <= bin;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < nSLICES; k++) begin
                        if (r_idx == IDXW'(k)) r_sum[4*k +: 4] <= w_s;
                    end
                    r_carry <= w_co;
                    if (w_last) begin
                        r_cout <= w_co;
                        r_idx  <= '0;
                    end else begin
                        r_idx  <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: a 16-bit instance (directed + random with
// backpressure + async reset) and a 4-bit instance swept exhaustively.

module tb_cla_seq_adder;
    localparam int W  = 16;
    localparam int W4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          iv16, ir16, ov16, or16, ci16, co16, busy16;
    logic [W-1:0]  a16, b16, s16;
    logic          iv4, ir4, ov4, or4, ci4, co4, busy4;
    logic [W4-1:0] a4, b4, s4;

    int checks = 0;
    int errors = 0;
    logic [W:0]  q16[$];
    logic [W4:0] q4[$];
    logic [W:0]  exp16;
    logic [W4:0] exp4;
    time t_acc16, t_acc4;
    bit  rnd_on;

    cla_seq_adder #(.nBITS(W)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .ain(a16), .bin(b16), .cin(ci16), .out_valid(ov16), .out_ready(or16),
        .sum(s16), .cout(co16), .busy(busy16)
    );

    cla_seq_adder #(.nBITS(W4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .ain(a4), .bin(b4), .cin(ci4), .out_valid(ov4), .out_ready(or4),
        .sum(s4), .cout(co4), .busy(busy4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    always @(negedge clk) begin
        if (rst_n && ov16 && or16) begin
            if (q16.size() == 0) fail("unexpected_result16");
            else begin
                exp16 = q16.pop_front();
                check("result16", {co16, s16}, exp16);
            end
        end
        if (rst_n && ov4 && or4) begin
            if (q4.size() == 0) fail("unexpected_result4");
            else begin
                exp4 = q4.pop_front();
                check("result4", {co4, s4}, exp4);
            end
        end
    end

    task automatic issue16(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int n = 0;
        a16 = a; b16 = b; ci16 = c; iv16 = 1'b1;
        forever begin
            @(negedge clk);
            if (ir16) break;
            n++;
            if (n > 100) begin
                fail("accept16");
                iv16 = 1'b0;
                return;
            end
        end
        q16.push_back({1'b0, a} + {1'b0, b} + (W+1)'(c));
        @(posedge clk);
        t_acc16 = $time;
        #1;
    endtask

    task automatic issue4(input logic [W4-1:0] a, input logic [W4-1:0] b, input logic c);
        int n = 0;
        a4 = a; b4 = b; ci4 = c; iv4 = 1'b1;
        forever begin
            @(negedge clk);
            if (ir4) break;
            n++;
            if (n > 100) begin
                fail("accept4");
                iv4 = 1'b0;
                return;
            end
        end
        q4.push_back({1'b0, a} + {1'b0, b} + (W4+1)'(c));
        @(posedge clk);
        t_acc4 = $time;
        #1;
    endtask

    task automatic wait_idle16();
        int n = 0;
        while (!ir16 && n < 100) begin @(negedge clk); n++; end
        if (!ir16) fail("idle16");
        @(posedge clk); #1;
    endtask

    initial begin
        time t_prev;
        logic [W:0] bp_exp;
        int n;
        rst_n = 1'b0;
        iv16 = 0; or16 = 0; a16 = '0; b16 = '0; ci16 = 0;
        iv4  = 0; or4  = 0; a4  = '0; b4  = '0; ci4  = 0;
        rnd_on = 0;

        repeat (2) @(posedge clk);
        #3;
        check("rst_sum16", s16, 0);
        check("rst_cout16", co16, 0);
        check("rst_valid16", ov16, 0);
        check("rst_busy16", busy16, 0);
        check("rst_valid4", ov4, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready16", ir16, 1);
        check("rel_ready4", ir4, 1);
        check("rel_busy16", busy16, 0);
        @(posedge clk); #1;

        // directed 0x1234 + 0x4321 with latency/handshake observation
        or16 = 1'b0;
        issue16(16'h1234, 16'h4321, 1'b0);
        iv16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hAAAA; ci16 = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check("t1_valid", ov16, (k == 4));
            check("t1_busy", busy16, 1);
            check("t1_ready", ir16, 0);
        end
        check("t1_sum", {co16, s16}, 17'h05555);
        @(posedge clk); #1 or16 = 1'b1;
        @(posedge clk); #1;
        check("t1_idle_ready", ir16, 1);
        check("t1_idle_valid", ov16, 0);

        // carry ripple through every slice
        issue16(16'hFFFF, 16'h0001, 1'b0);
        issue16(16'hFFFF, 16'h0000, 1'b1);
        issue16(16'h8000, 16'h8000, 1'b0);
        iv16 = 1'b0;
        wait_idle16();

        // back-to-back issue interval
        issue16(W'($urandom), W'($urandom), 1'($urandom));
        t_prev = t_acc16;
        for (int k = 0; k < 2; k++) begin
            issue16(W'($urandom), W'($urandom), 1'($urandom));
            check("b2b_interval16", t_acc16 - t_prev, 60);
            t_prev = t_acc16;
        end
        iv16 = 1'b0;
        wait_idle16();

        // backpressure in DONE with in_valid and toggling operands
        or16 = 1'b0;
        a16 = W'($urandom); b16 = W'($urandom); ci16 = 1'($urandom);
        bp_exp = {1'b0, a16} + {1'b0, b16} + (W+1)'(ci16);
        issue16(a16, b16, ci16);
        iv16 = 1'b0;
        n = 0;
        while (!ov16 && n < 20) begin @(negedge clk); n++; end
        if (!ov16) fail("bp_done");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            a16 = W'($urandom); b16 = W'($urandom); ci16 = 1'($urandom); iv16 = 1'b1;
            @(negedge clk);
            check("bp_valid", ov16, 1);
            check("bp_result", {co16, s16}, bp_exp);
            check("bp_ready", ir16, 0);
        end
        @(posedge clk); #1 or16 = 1'b1; iv16 = 1'b0;
        @(posedge clk); #1;
        check("bp_release_ready", ir16, 1);
        check("bp_release_valid", ov16, 0);

        // random operands with random consumer backpressure
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk); #1;
                if (rnd_on) or16 = 1'($urandom_range(0, 1));
            end
        join_none
        for (int k = 0; k < 100; k++)
            issue16(W'($urandom), W'($urandom), 1'($urandom));
        iv16 = 1'b0;
        rnd_on = 1'b0;
        repeat (2) @(posedge clk);
        #1 or16 = 1'b1;
        wait_idle16();

        // asynchronous reset mid-RUN discards the operation
        issue16(16'h1234, 16'h1111, 1'b1);
        iv16 = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_sum", s16, 0);
        check("arst_cout", co16, 0);
        check("arst_valid", ov16, 0);
        check("arst_busy", busy16, 0);
        q16.delete();
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        issue16(16'h00FF, 16'h0F0F, 1'b0);
        iv16 = 1'b0;
        wait_idle16();
        check("post_arst_sum", {co16, s16}, 17'h0100E);

        // 4-bit exhaustive sweep, one RUN cycle each
        or4 = 1'b1;
        for (int v = 0; v < 512; v++) begin
            issue4(W4'(v >> 5), W4'(v >> 1), 1'(v));
            if (v > 0) check("b2b_interval4", t_acc4 - t_prev, 30);
            t_prev = t_acc4;
        end
        iv4 = 1'b0;

        n = 0;
        while ((q16.size() != 0 || q4.size() != 0) && n < 200) begin
            @(posedge clk); n++;
        end
        if (q16.size() != 0 || q4.size() != 0) fail("drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
Multi-cycle N-bit adder controller that time-shares one 4-bit carry-lookahead adder slice across an nBITS-wide operand pair.
- Processes 4 bits per cycle, least-significant slice first.
- Holds the inter-slice carry in a register.
- Uses valid/ready handshakes on both input and output.
- Sits between an operand producer and a result consumer as the area-saving alternative to a full-width CLA.

Parameters:
nBITS, 16, operand/result width; must be a multiple of 4 and at least 4.
nSLICES, nBITS/4, derived (localparam): number of 4-bit slices, and so the number of RUN cycles.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  producer presents ain/bin/cin.
in_ready  output  1  block can accept operands; high only in IDLE.
ain  input  nBITS  operand A.
bin  input  nBITS  operand B.
cin  input  1  carry-in to the least-significant slice.
out_valid  output  1  sum/cout hold a completed result.
out_ready  input  1  consumer accepts the result.
sum  output  nBITS  registered result.
cout  output  1  registered carry-out of the most-significant slice.
busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n); it takes effect immediately, independent of clk.
- Reset values:
  - state=IDLE, slice index=0, carry register=0
  - operand registers=0, sum=0, cout=0
  - out_valid=0, busy=0, in_ready=1 once rst_n is released
- Datapath:
  - One 4-bit CLA slice is instantiated.
  - Its inputs are slice idx of the latched A and B plus the carry register.
  - Its outputs are 4 sum bits and a slice carry-out.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: latch ain, bin; carry register<=cin; idx<=0; sum<=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: sum[4*idx+3:4*idx] <= slice sum; carry <= slice cout; idx <= idx+1.
  - On the edge where idx==nSLICES-1: cout <= slice cout, out_valid <= 1, go to DONE, idx returns to 0.
- DONE:
  - out_valid=1, busy=1, in_ready=0.
  - sum/cout held stable until handshake.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE.
  - in_valid is ignored while in DONE; no same-cycle re-accept.
- Latency and throughput:
  - Acceptance edge, then nSLICES RUN edges.
  - out_valid is high from the nSLICES-th edge after acceptance.
  - Minimum issue interval is nSLICES+2 cycles per operation.
- Arithmetic:
  - {cout,sum} must equal ain + bin + cin modulo 2^(nBITS+1) for all inputs.
  - The carry propagates only through the carry register between slices.
- Boundary conditions:
  - idx never exceeds nSLICES-1.
  - With nBITS=4, RUN lasts exactly one cycle.
  - Operand changes on ain/bin/cin after acceptance have no effect on the result in flight.
- Reset mid-operation (RUN or DONE): the result is discarded; all registers return to their reset values asynchronously; no out_valid is produced for the aborted operation.
- Illegal state encodings recover to IDLE on the next edge.

Test Plan:
1. nBITS=16; accept ain=0x1234, bin=0x4321, cin=0 -> after 4 RUN cycles out_valid=1, sum=0x5555, cout=0; busy high throughout, in_ready low until return to IDLE.
2. nBITS=16; ain=0xFFFF, bin=0x0001, cin=0 -> sum=0x0000, cout=1, showing the carry rippling through all 4 slice registers. Repeat with ain=0xFFFF, bin=0x0000, cin=1 -> sum=0x0000, cout=1. Repeat with ain=0x8000, bin=0x8000, cin=0 -> sum=0x0000, cout=1.
3. Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands toggling -> sum/cout/out_valid stable, in_ready=0, no new acceptance. Then out_ready=1 -> IDLE next cycle, in_ready=1.
4. Back-to-back: in_valid held high and out_ready held high with 3 operand pairs queued -> 3 correct results, each issued 6 cycles apart.
5. Reset mid-RUN: deassert rst_n asynchronously (between clock edges) during the 2nd RUN cycle -> outputs zero immediately, state IDLE. After release, the next operation 0x00FF+0x0F0F, cin=0 -> sum=0x100E, cout=0.
6. nBITS=4 exhaustive: all 512 combinations of ain, bin, cin compared against ain+bin+cin -> zero mismatches, each with a 1-cycle RUN phase.
